branch_cmp_unit: RTL and testbench
==================================

# branch_cmp_unit

Parametrised branch-condition resolver for the ID stage of the pipelined MIPS core; successor of the single-cycle comparator. Accepts a branch request over a valid/ready handshake and waits in place until the forwarding network marks the needed operands resolved. It then registers a taken/not-taken result and holds it until the PC-select logic consumes it. Supports six signed conditions, flushes on exception/redirect, and optionally counts resolved and taken branches.

## Interface
- `WIDTH`, 32: operand width in bits (≥2).
- `CNT_W`, 32: width of each performance counter (used only with `BCU_PERF_CNT_EN`).
- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous kill of any in-flight request.
- `in_valid`  in  1: branch request present.
- `in_ready`  out  1: unit can accept a request this cycle.
- `in_op`  in  4: condition code, sampled on accept.
- `rs`, `rt`  in  WIDTH: live forwarded operand buses, sampled every cycle while pending.
- `rs_ok`, `rt_ok`  in  1: corresponding operand bus holds a resolved value.
- `out_valid`  out  1: result held.
- `out_ready`  in  1: consumer takes result.
- `out_taken`  out  1: condition true.
- `out_bad_op`  out  1: captured op was undefined.
- `perf_total`, `perf_taken`  out  CNT_W: counters (only with `BCU_PERF_CNT_EN`).

## Operation
- Op codes (signed compare on WIDTH bits): BEQ 4'h0 rs==rt; BGEZ 4'h1 rs≥0; BNE 4'h2 rs!=rt; BLEZ 4'h3 rs≤0; BGTZ 4'h4 rs>0; BLTZ 4'h5 rs<0. All other codes are undefined: taken=0, bad_op=1, and no operands are needed.
- Operand need: BEQ/BNE need rs_ok&rt_ok; the other defined ops need rs_ok only.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: in_ready=1. On accept, latch op. If the needed operands are ok in the same cycle, evaluate and go to DONE; otherwise go to WAIT.
  - WAIT: in_ready=0. Each cycle, when the needed operands are ok, evaluate the current rs/rt and go to DONE; otherwise stay.
  - DONE: out_valid=1 and out_taken/out_bad_op are stable. in_ready=out_ready. When out_ready is high, either accept a new request back-to-back (same rules as IDLE) or return to IDLE.
- flush has highest priority: next state IDLE, out_valid=0, in_ready=0 during the flush cycle, any request presented that cycle is dropped, and counters are not updated.
- Result registers update only on evaluation and are otherwise held.

## Timing
- Reset values: state IDLE, out_valid=0, out_taken=0, out_bad_op=0, perf counters 0. in_ready=1 after reset deasserts.
- Latency: with operands ok at accept, out_valid is high in the cycle after accept. Each cycle of missing operands adds exactly one cycle.
- Throughput: one branch per cycle when operands are ready and out_ready is held high.
- Reset asserted mid-WAIT or mid-DONE clears everything immediately (asynchronous); no result is emitted.
- Operand changes while in DONE do not affect the held result.
- An undefined op is resolved like a ready branch: DONE in the next cycle.

## Configuration
- `BCU_PERF_CNT_EN` defined: perf_total increments on every out_valid&out_ready handshake; perf_taken also increments when out_taken=1. Both saturate at all-ones and ignore flushed requests.
- Not defined: counter ports and registers are absent, and the logic is otherwise identical.

## Structure
- Package `bcu_pkg`: the op code constants (BEQ…BLTZ), the FSM state enum, and the operand-need function.
- Sub-module `bcu_cond_eval`: combinational; inputs op, rs, rt; outputs taken and bad_op. Parametrised by WIDTH and instantiated once.

## Test plan
- Ready BEQ: rs=rt=32'h1234, both ok, out_ready=1 → next cycle out_valid=1, out_taken=1; then BNE with the same operands → out_taken=0.
- Signed boundaries: rs=32'h8000_0000 → BLTZ taken, BGEZ not taken, BLEZ taken, BGTZ not taken; rs=0 → BGEZ and BLEZ taken, BGTZ and BLTZ not taken.
- Forward wait: BEQ with rt_ok=0 for 3 cycles, then rt becomes equal to rs with rt_ok=1 → in_ready=0 while pending, out_valid rises exactly 1 cycle after rt_ok, taken=1.
- Backpressure/back-to-back: out_ready=0 for 4 cycles → result held stable and in_ready=0; then out_ready=1 with a new request → second request accepted in the same cycle.
- Flush in WAIT and in DONE, and flush concurrent with in_valid → state IDLE, no out_valid, request dropped, perf_total unchanged.
- Undefined op 4'hF → DONE next cycle, taken=0, bad_op=1. With `BCU_PERF_CNT_EN` and CNT_W=4, after 20 taken handshakes → perf_taken=4'hF (saturated).

Source files
------------

// File: rtl/bcu_pkg.sv
// Shared definitions for the branch compare unit: op codes, FSM states and operand-need decode.
package bcu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_BEQ  = 4'h0;
  localparam logic [OP_W-1:0] OP_BGEZ = 4'h1;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h2;
  localparam logic [OP_W-1:0] OP_BLEZ = 4'h3;
  localparam logic [OP_W-1:0] OP_BGTZ = 4'h4;
  localparam logic [OP_W-1:0] OP_BLTZ = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {needs_rs, needs_rt}; undefined ops need nothing so they resolve at once.
  function automatic logic [1:0] op_need(input logic [OP_W-1:0] op);
    logic [1:0] need;
    case (op)
      OP_BEQ, OP_BNE:                     need = 2'b11;
      OP_BGEZ, OP_BLEZ, OP_BGTZ, OP_BLTZ: need = 2'b10;
      default:                            need = 2'b00;
    endcase
    return need;
  endfunction

  function automatic logic ops_ready(input logic [OP_W-1:0] op, input logic rs_ok,
                                     input logic rt_ok);
    logic [1:0] need;
    need = op_need(op);
    return (~need[1] | rs_ok) & (~need[0] | rt_ok);
  endfunction

endpackage

// File: rtl/bcu_cond_eval.sv
// Combinational signed branch-condition evaluator.
module bcu_cond_eval
  import bcu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             taken,
  output logic             bad_op
);

  logic eq;
  logic neg;
  logic zero;

  assign eq   = (rs == rt);
  assign neg  = rs[WIDTH-1];
  assign zero = (rs == '0);

  always_comb begin
    taken  = 1'b0;
    bad_op = 1'b0;
    case (op)
      OP_BEQ:  taken = eq;
      OP_BGEZ: taken = ~neg;
      OP_BNE:  taken = ~eq;
      OP_BLEZ: taken = neg | zero;
      OP_BGTZ: taken = ~neg & ~zero;
      OP_BLTZ: taken = neg;
      default: bad_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_cmp_unit.sv
// Branch-condition resolver: waits for forwarded operands, holds the result until consumed.
// Optional performance counters are built when BCU_PERF_CNT_EN is defined.
module branch_cmp_unit
  import bcu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
`ifdef BCU_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             rs_ok,
  input  logic             rt_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_bad_op
`ifdef BCU_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_total
  , output logic [CNT_W-1:0] perf_taken
`endif
);

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] op_sel;
  logic            taken_q;
  logic            bad_q;
  logic            accept;
  logic            eval;
  logic            eval_taken;
  logic            eval_bad;

  // On accept the incoming op is evaluated directly; while waiting the latched op is used.
  bcu_cond_eval #(.WIDTH(WIDTH)) u_eval (
    .op     (op_sel),
    .rs     (rs),
    .rt     (rt),
    .taken  (eval_taken),
    .bad_op (eval_bad)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    eval     = 1'b0;
    op_sel   = op_q;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ST_WAIT: begin
        if (ops_ready(op_q, rs_ok, rt_ok)) begin
          eval    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          accept  = in_valid;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      op_sel = in_op;
      if (ops_ready(in_op, rs_ok, rt_ok)) begin
        eval    = 1'b1;
        state_d = ST_DONE;
      end else begin
        state_d = ST_WAIT;
      end
    end
    // Flush overrides everything, including a request arriving the same cycle.
    if (flush) begin
      state_d  = ST_IDLE;
      in_ready = 1'b0;
      accept   = 1'b0;
      eval     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      taken_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      if (accept) op_q <= in_op;
      if (eval) begin
        taken_q <= eval_taken;
        bad_q   <= eval_bad;
      end
    end
  end

  assign out_valid  = (state_q == ST_DONE) & ~flush;
  assign out_taken  = taken_q;
  assign out_bad_op = bad_q;

`ifdef BCU_PERF_CNT_EN
  logic handshake;
  assign handshake = out_valid & out_ready;

  // Saturating counters; flushed results never handshake so they are never counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_total <= '0;
      perf_taken <= '0;
    end else if (handshake) begin
      if (perf_total != '1)            perf_total <= perf_total + CNT_W'(1);
      if (taken_q && perf_taken != '1) perf_taken <= perf_taken + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Scoreboard bench for branch_cmp_unit: directed vectors, decoupled result monitor.
module tb_branch_cmp_unit;
  import bcu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             rs_ok;
  logic             rt_ok;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_bad_op;

`ifdef BCU_PERF_CNT_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] perf_total;
  logic [CNT_W-1:0] perf_taken;

  function automatic int sat(input int v);
    int mx;
    mx = (1 << CNT_W) - 1;
    return (v > mx) ? mx : v;
  endfunction

  branch_cmp_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
`else
  branch_cmp_unit #(.WIDTH(WIDTH)) dut (
`endif
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .rs         (rs),
    .rt         (rt),
    .rs_ok      (rs_ok),
    .rt_ok      (rt_ok),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_bad_op (out_bad_op)
`ifdef BCU_PERF_CNT_EN
    , .perf_total (perf_total)
    , .perf_taken (perf_taken)
`endif
  );

  typedef struct packed {
    logic taken;
    logic bad;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests;
  int   fails;
  int   hs_total;
  int   hs_taken;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request with operands resolved; it must be accepted at the next edge.
  task automatic issue(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit push, input logic exp_taken,
                       input logic exp_bad, input string name);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    rs       = a;
    rt       = b;
    rs_ok    = 1'b1;
    rt_ok    = 1'b1;
    e.taken  = exp_taken;
    e.bad    = exp_bad;
    if (push) sb.push_back(e);
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({name, "_latency"}, out_valid, 1);
  endtask

  // Monitor: every consumed result must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got out_valid=1 required no pending result");
      end else begin
        mon_e = sb.pop_front();
        check("result_taken", out_taken, mon_e.taken);
        check("result_bad_op", out_bad_op, mon_e.bad);
        hs_total++;
        if (mon_e.taken) hs_taken++;
      end
    end
  end

  initial begin
    clk = 0; reset_n = 0; flush = 0; in_valid = 0; in_op = '0;
    rs = '0; rt = '0; rs_ok = 1; rt_ok = 1; out_ready = 1;
    tests = 0; fails = 0; hs_total = 0; hs_taken = 0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_taken", out_taken, 0);
    check("rst_out_bad_op", out_bad_op, 0);
`ifdef BCU_PERF_CNT_EN
    check("rst_perf_total", perf_total, 0);
    check("rst_perf_taken", perf_taken, 0);
`endif
    tick();
    reset_n = 1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // Basic equality conditions, issued back-to-back
    issue(OP_BEQ, 32'h1234, 32'h1234, 1, 1, 0, "beq_eq");
    issue(OP_BNE, 32'h1234, 32'h1234, 1, 0, 0, "bne_eq");
    issue(OP_BNE, 32'h1, 32'h2, 1, 1, 0, "bne_ne");
    issue(OP_BEQ, 32'h1, 32'h2, 1, 0, 0, "beq_ne");

    // Signed boundaries
    issue(OP_BLTZ, 32'h8000_0000, 32'h0, 1, 1, 0, "bltz_min");
    issue(OP_BGEZ, 32'h8000_0000, 32'h0, 1, 0, 0, "bgez_min");
    issue(OP_BLEZ, 32'h8000_0000, 32'h0, 1, 1, 0, "blez_min");
    issue(OP_BGTZ, 32'h8000_0000, 32'h0, 1, 0, 0, "bgtz_min");
    issue(OP_BGEZ, 32'h0, 32'h5, 1, 1, 0, "bgez_zero");
    issue(OP_BLEZ, 32'h0, 32'h5, 1, 1, 0, "blez_zero");
    issue(OP_BGTZ, 32'h0, 32'h5, 1, 0, 0, "bgtz_zero");
    issue(OP_BLTZ, 32'h0, 32'h5, 1, 0, 0, "bltz_zero");
    issue(OP_BGTZ, 32'h7FFF_FFFF, 32'h0, 1, 1, 0, "bgtz_max");
    issue(OP_BLEZ, 32'h1, 32'h0, 1, 0, 0, "blez_one");
    tick();
    tick();

    // Forward wait: rt unresolved for three cycles, live rt sampled on resolve
    in_valid = 1; in_op = OP_BEQ; rs = 32'h5; rt = 32'h0; rs_ok = 1; rt_ok = 0;
    sb.push_back('{taken: 1'b1, bad: 1'b0});
    tick();
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      rt = 32'(i + 9);
      @(negedge clk);
      check("fwd_in_ready", in_ready, 0);
      check("fwd_out_valid", out_valid, 0);
      tick();
    end
    rt = 32'h5; rt_ok = 1;
    @(negedge clk);
    check("fwd_valid_pre", out_valid, 0);
    check("fwd_in_ready_pre", in_ready, 0);
    tick();
    check("fwd_valid_post", out_valid, 1);
    check("fwd_taken", out_taken, 1);
    tick();
    tick();

    // Backpressure: result held across operand changes, then back-to-back accept
    out_ready = 0;
    issue(OP_BGTZ, 32'h7, 32'h0, 1, 1, 0, "bp_first");
    for (int i = 0; i < 4; i++) begin
      rs = 32'hFFFF_FFF0;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_taken", out_taken, 1);
      check("bp_out_bad_op", out_bad_op, 0);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    issue(OP_BLTZ, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, "bp_second");
    tick();
    tick();

    // Flush while waiting for operands
    in_valid = 1; in_op = OP_BGEZ; rs = 32'h3; rs_ok = 0;
    tick();
    in_valid = 0; flush = 1; rs_ok = 1;
    @(negedge clk);
    check("flw_in_ready", in_ready, 0);
    check("flw_out_valid", out_valid, 0);
    tick();
    flush = 0;
    check("flw_after_valid", out_valid, 0);
    @(negedge clk);
    check("flw_after_ready", in_ready, 1);
    tick();

    // Flush while holding a result
    out_ready = 0;
    issue(OP_BEQ, 32'h1, 32'h1, 0, 1, 0, "fld_issue");
    flush = 1;
    @(negedge clk);
    check("fld_out_valid", out_valid, 0);
    check("fld_in_ready", in_ready, 0);
    tick();
    flush = 0; out_ready = 1;
    check("fld_after_valid", out_valid, 0);
    tick();

    // Flush concurrent with a new request
    flush = 1; in_valid = 1; in_op = OP_BEQ; rs = 32'h2; rt = 32'h2;
    @(negedge clk);
    check("flr_in_ready", in_ready, 0);
    tick();
    flush = 0; in_valid = 0;
    check("flr_out_valid", out_valid, 0);
    tick();
    check("flr_out_valid2", out_valid, 0);
`ifdef BCU_PERF_CNT_EN
    check("flush_perf_total", perf_total, sat(hs_total));
`endif

    // Undefined ops resolve at once without operands
    in_valid = 1; in_op = 4'hF; rs_ok = 0; rt_ok = 0;
    sb.push_back('{taken: 1'b0, bad: 1'b1});
    @(negedge clk);
    check("undef_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("undef_out_valid", out_valid, 1);
    check("undef_bad_op", out_bad_op, 1);
    check("undef_taken", out_taken, 0);
    issue(4'h6, 32'h0, 32'h0, 1, 0, 1, "undef6");
    tick();
    tick();

    // Long run of taken branches to saturate narrow counters
    for (int i = 0; i < 20; i++) issue(OP_BEQ, 32'(i), 32'(i), 1, 1, 0, "sat");
    tick();
    tick();
`ifdef BCU_PERF_CNT_EN
    check("sat_perf_taken", perf_taken, sat(hs_taken));
    check("sat_perf_total", perf_total, sat(hs_total));
`endif

    // Asynchronous reset while holding a result
    out_ready = 0;
    issue(OP_BNE, 32'h1, 32'h2, 0, 1, 0, "rstd_issue");
    #3 reset_n = 0;
    #1;
    check("rstd_out_valid", out_valid, 0);
    check("rstd_out_taken", out_taken, 0);
    check("rstd_in_ready", in_ready, 1);
`ifdef BCU_PERF_CNT_EN
    check("rstd_perf_total", perf_total, 0);
`endif
    tick();
    reset_n = 1; out_ready = 1;
    tick();

    // Asynchronous reset while waiting
    in_valid = 1; in_op = OP_BGEZ; rs = 32'h1; rs_ok = 0;
    tick();
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    check("rstw_out_valid", out_valid, 0);
    tick();
    reset_n = 1; rs_ok = 1;
    tick();
    check("rstw_after_valid", out_valid, 0);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
